sc_shift_sequencer: RTL
=======================

SC_SHIFT_SEQUENCER -- requirements
Module: sc_shift_sequencer

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32, SHALL set the data bus width.
REQ-002 Parameter DATAWIDTH_REGSHIFTER_SELECTION, default 2, SHALL set the shift-selection code width.
REQ-003 Parameter DATAWIDTH_COUNT, default 5, SHALL set the shift-count width.
REQ-004 SC_SHIFT_SEQUENCER_CLOCK_50  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 SC_SHIFT_SEQUENCER_Reset_InLow  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 SC_SHIFT_SEQUENCER_Start_InLow  in  1  SHALL be the command strobe; active low.
REQ-007 SC_SHIFT_SEQUENCER_Direction_In  in  1  SHALL select direction: 0 = left, 1 = right.
REQ-008 SC_SHIFT_SEQUENCER_Count_In  in  DATAWIDTH_COUNT  SHALL give the number of single-bit shifts.
REQ-009 SC_SHIFT_SEQUENCER_DataBUS_In  in  DATAWIDTH_BUS  SHALL carry the operand to be loaded.
REQ-010 SC_SHIFT_SEQUENCER_Load_OutLow  out  1  SHALL drive the downstream shift register's active-low load.
REQ-011 SC_SHIFT_SEQUENCER_ShiftSelection_OutLow  out  DATAWIDTH_REGSHIFTER_SELECTION  SHALL drive the downstream shift select: 01 = left, 10 = right, 00 = hold.
REQ-012 SC_SHIFT_SEQUENCER_DataBUS_Out  out  DATAWIDTH_BUS  SHALL present the captured operand to the downstream load input.
REQ-013 SC_SHIFT_SEQUENCER_Busy_OutHigh  out  1  SHALL be high whenever a command is in progress.
REQ-014 SC_SHIFT_SEQUENCER_Done_OutHigh  out  1  SHALL pulse high for one cycle at command completion.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE, and all outputs SHALL be registered (Moore).
REQ-016 In IDLE, Start_InLow=0 at a rising edge SHALL capture DataBUS_In, Direction_In and Count_In, and the FSM SHALL move to LOAD.
REQ-017 Start_InLow SHALL be ignored in LOAD, SHIFT and DONE; there is no command queueing.
REQ-018 In LOAD (exactly one cycle), Load_OutLow SHALL be 0, ShiftSelection_OutLow SHALL be 00, and DataBUS_Out SHALL equal the captured operand.
REQ-019 LOAD SHALL go to SHIFT if the captured count is nonzero, and to DONE if it is zero.
REQ-020 In SHIFT, Load_OutLow SHALL be 1 and ShiftSelection_OutLow SHALL be 01 (left) or 10 (right) for exactly N consecutive cycles, N being the captured count (N = 1..2^DATAWIDTH_COUNT-1), with an internal down-counter decremented each SHIFT cycle.
REQ-021 SHIFT SHALL go to DONE in the cycle after the one in which the counter reaches 1; the counter SHALL never wrap below 0.
REQ-022 In DONE (exactly one cycle), Done_OutHigh SHALL be 1, ShiftSelection_OutLow SHALL be 00 and Load_OutLow SHALL be 1, and the next state SHALL be IDLE.
REQ-023 Busy_OutHigh SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-024 Latency: with Start sampled at edge k, LOAD SHALL occupy cycle k+1, SHIFT cycles k+2..k+1+N, DONE cycle k+2+N and IDLE cycle k+3+N; a new Start SHALL be accepted at edge k+3+N at the earliest.
REQ-025 Outside LOAD, Load_OutLow SHALL be 1 and DataBUS_Out SHALL hold the last captured operand.
REQ-026 Code 11 SHALL never be driven on ShiftSelection_OutLow.

Reset
REQ-027 Reset_InLow=0 at a rising edge SHALL force IDLE with Load_OutLow=1, ShiftSelection_OutLow=00, DataBUS_Out=0, Busy_OutHigh=0, Done_OutHigh=0 and the counter at 0.
REQ-028 Reset SHALL take priority over Start and over any state, including mid-SHIFT; the remaining shifts SHALL be discarded and no Done pulse SHALL be issued.

Configuration
REQ-029 Macro SHIFT_SEQUENCER_ABORT_EN defined SHALL add the input SC_SHIFT_SEQUENCER_Abort_InLow (1 bit).
REQ-030 With the macro defined, Abort_InLow=0 at an edge in LOAD or SHIFT SHALL go to DONE next: ShiftSelection_OutLow returns to 00, the remaining count is discarded, and Done pulses normally; Abort SHALL be ignored in IDLE and DONE.
REQ-031 With the macro undefined, the port SHALL be absent and the behaviour SHALL be REQ-015..REQ-028 only.

Verification
REQ-032 Start, Dir=0, Count=3, Data=0x0000_0001: LOAD one cycle with Data_Out=0x1, then three cycles of code 01, then Done; downstream register = 0x0000_0008.
REQ-033 Start, Dir=1, Count=31, Data=0x8000_0000: 31 cycles of code 10, Done at cycle k+33; downstream register = 0x0000_0001.
REQ-034 Start, Count=0, Data=0xA5A5_A5A5: LOAD then DONE directly with no shift code; downstream register = 0xA5A5_A5A5; Busy high for 2 cycles.
REQ-035 Start held low throughout a Count=2 command: exactly one command executes; a second command starts only at the IDLE edge after DONE.
REQ-036 Reset_InLow=0 during the 2nd SHIFT cycle of a Count=5 command: next cycle shows all reset values, no Done pulse, and selection 00 thereafter.
REQ-037 (ABORT_EN) Abort_InLow=0 in the 1st SHIFT cycle of a Count=10 left shift of 0x1: exactly 1 left-shift cycle, Done next cycle, downstream register = 0x2.

Source files
------------

// File: rtl/sc_shift_sequencer.sv
// sc_shift_sequencer: command sequencer for a downstream shift register.
// A Start command captures an operand, a direction and a shift count, then
// drives one load cycle, N shift cycles and a one-cycle Done pulse.
// All outputs are registered (Moore), and the reset is synchronous and active-low.
// Optional build macro SHIFT_SEQUENCER_ABORT_EN adds SC_SHIFT_SEQUENCER_Abort_InLow.
// When the macro is defined, an abort in LOAD or SHIFT jumps to DONE.
module sc_shift_sequencer #(
  parameter int DATAWIDTH_BUS                  = 32,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int DATAWIDTH_COUNT                = 5
) (
  input  logic                                      SC_SHIFT_SEQUENCER_CLOCK_50,
  input  logic                                      SC_SHIFT_SEQUENCER_Reset_InLow,
  input  logic                                      SC_SHIFT_SEQUENCER_Start_InLow,
  input  logic                                      SC_SHIFT_SEQUENCER_Direction_In,
  input  logic [DATAWIDTH_COUNT-1:0]                SC_SHIFT_SEQUENCER_Count_In,
  input  logic [DATAWIDTH_BUS-1:0]                  SC_SHIFT_SEQUENCER_DataBUS_In,
`ifdef SHIFT_SEQUENCER_ABORT_EN
  input  logic                                      SC_SHIFT_SEQUENCER_Abort_InLow,
`endif
  output logic                                      SC_SHIFT_SEQUENCER_Load_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_SHIFT_SEQUENCER_ShiftSelection_OutLow,
  output logic [DATAWIDTH_BUS-1:0]                  SC_SHIFT_SEQUENCER_DataBUS_Out,
  output logic                                      SC_SHIFT_SEQUENCER_Busy_OutHigh,
  output logic                                      SC_SHIFT_SEQUENCER_Done_OutHigh
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_HOLD  = '0;
  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_LEFT  = DATAWIDTH_REGSHIFTER_SELECTION'(1);
  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_RIGHT = DATAWIDTH_REGSHIFTER_SELECTION'(2);
  localparam logic [DATAWIDTH_COUNT-1:0]                CNT_ONE   = DATAWIDTH_COUNT'(1);

  state_t                     stateReg;
  logic [DATAWIDTH_COUNT-1:0] countReg;
  logic                       dirReg;
  logic                       abortReq;

`ifdef SHIFT_SEQUENCER_ABORT_EN
  assign abortReq = ~SC_SHIFT_SEQUENCER_Abort_InLow;
`else
  assign abortReq = 1'b0;
`endif

  // FSM with state, counter and all outputs updated together on the clock edge
  always_ff @(posedge SC_SHIFT_SEQUENCER_CLOCK_50) begin
    if (!SC_SHIFT_SEQUENCER_Reset_InLow) begin
      stateReg                                 <= IDLE;
      countReg                                 <= '0;
      dirReg                                   <= 1'b0;
      SC_SHIFT_SEQUENCER_Load_OutLow           <= 1'b1;
      SC_SHIFT_SEQUENCER_ShiftSelection_OutLow <= SEL_HOLD;
      SC_SHIFT_SEQUENCER_DataBUS_Out           <= '0;
      SC_SHIFT_SEQUENCER_Busy_OutHigh          <= 1'b0;
      SC_SHIFT_SEQUENCER_Done_OutHigh          <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          SC_SHIFT_SEQUENCER_Done_OutHigh <= 1'b0;
          if (!SC_SHIFT_SEQUENCER_Start_InLow) begin
            stateReg                                 <= LOAD;
            countReg                                 <= SC_SHIFT_SEQUENCER_Count_In;
            dirReg                                   <= SC_SHIFT_SEQUENCER_Direction_In;
            SC_SHIFT_SEQUENCER_DataBUS_Out           <= SC_SHIFT_SEQUENCER_DataBUS_In;
            SC_SHIFT_SEQUENCER_Load_OutLow           <= 1'b0;
            SC_SHIFT_SEQUENCER_ShiftSelection_OutLow <= SEL_HOLD;
            SC_SHIFT_SEQUENCER_Busy_OutHigh          <= 1'b1;
          end
        end
        LOAD: begin
          SC_SHIFT_SEQUENCER_Load_OutLow <= 1'b1;
          if (abortReq || countReg == '0) begin
            // Either an abort or a zero-length command goes straight to DONE.
            stateReg                                 <= DONE;
            countReg                                 <= '0;
            SC_SHIFT_SEQUENCER_ShiftSelection_OutLow <= SEL_HOLD;
            SC_SHIFT_SEQUENCER_Done_OutHigh          <= 1'b1;
          end else begin
            stateReg                                 <= SHIFT;
            SC_SHIFT_SEQUENCER_ShiftSelection_OutLow <= dirReg ? SEL_RIGHT : SEL_LEFT;
          end
        end
        SHIFT: begin
          // The counter holds the number of shift cycles left, including this one.
          if (abortReq || countReg <= CNT_ONE) begin
            stateReg                                 <= DONE;
            countReg                                 <= '0;
            SC_SHIFT_SEQUENCER_ShiftSelection_OutLow <= SEL_HOLD;
            SC_SHIFT_SEQUENCER_Done_OutHigh          <= 1'b1;
          end else begin
            countReg <= countReg - CNT_ONE;
          end
        end
        DONE: begin
          stateReg                        <= IDLE;
          SC_SHIFT_SEQUENCER_Done_OutHigh <= 1'b0;
          SC_SHIFT_SEQUENCER_Busy_OutHigh <= 1'b0;
        end
        default: begin
          stateReg                                 <= IDLE;
          countReg                                 <= '0;
          SC_SHIFT_SEQUENCER_Load_OutLow           <= 1'b1;
          SC_SHIFT_SEQUENCER_ShiftSelection_OutLow <= SEL_HOLD;
          SC_SHIFT_SEQUENCER_Busy_OutHigh          <= 1'b0;
          SC_SHIFT_SEQUENCER_Done_OutHigh          <= 1'b0;
        end
      endcase
    end
  end

endmodule
